pp_rr_arbiter: RTL and testbench
================================

Name: pp_rr_arbiter

Overview:
- N-way round-robin arbiter that merges N rdy/ack/dat streams onto one shared downstream pipeline stage.
- Has a one-entry registered output buffer.
- Sits in front of any single-consumer datapath so that several producers can share it at full throughput (one word per cycle).
- All inputs and the output obey the pipeline protocol: once rdy is high, rdy and dat hold stable until ack.

Parameters:
- N, 4, number of requesters (N >= 2).
- BW, 8, data width in bits.
- IW, $clog2(N), width of the grant index (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- i_rdy  input  N  per-requester data valid.
- i_dat  input  N*BW  requester k occupies bits [k*BW +: BW].
- o_ack  output  N  per-requester accept; combinational, at most one bit high.
- o_rdy  output  1  output word valid (registered).
- o_dat  output  BW  output word (registered).
- o_src  output  IW  index of the requester that supplied o_dat (registered).
- i_ack  input  1  downstream accept.

Behaviour:
- Reset values: o_rdy=0, o_dat=0, o_src=0, last-grant pointer ptr=N-1, so requester 0 has top priority after reset.
- State machine with two states:
  - EMPTY: o_rdy=0.
  - FULL: o_rdy=1.
- can_take = (state==EMPTY) | i_ack.
- Winner: the first k with i_rdy[k]=1, scanning ptr+1, ptr+2, ... with wrap modulo N (N need not be a power of 2).
- o_ack[k] = can_take & i_rdy[k] & (k==winner). o_ack depends on i_ack combinationally. Downstream must not derive i_ack from o_ack.
- On a cycle where any o_ack is high: o_dat<=i_dat[winner], o_src<=winner, ptr<=winner, next state FULL.
- EMPTY -> FULL when any i_rdy is high. Latency is 1 cycle, i_rdy to o_rdy.
- FULL with i_ack=0: hold o_dat and o_src stable, o_ack=0. Output protocol is met.
- FULL with i_ack=1 and some i_rdy: refill in the same cycle, stay FULL. Sustains 1 word per cycle with no bubble.
- FULL with i_ack=1 and no i_rdy: go to EMPTY. o_dat keeps its old value (don't-care).
- ptr changes only on an accepted word. Idle cycles do not rotate priority.
- Single active requester: granted every cycle regardless of ptr.
- Fairness: with all N requesters continuously ready, grants go ptr+1, ptr+2, ... strictly cyclic. Maximum wait is N-1 accepted words.
- A requester dropping rdy without ack is a protocol violation by the producer. The arbiter does not check for it.
- Reset asserted mid-operation: the buffered word is discarded, o_ack goes low immediately (can_take is forced 0 while rst=1), and ptr returns to N-1.

Optional Feature:
- Macro: PP_ARB_PKT_LOCK_EN.
- With the macro defined:
  - Adds ports i_last (input, N bits) and o_last (output, 1 bit, registered, reset 0).
  - Adds a lock flag (reset 0) and lock_idx.
  - Accepting a word with i_last[winner]=0 sets lock=1, lock_idx=winner.
  - Accepting a word with i_last=1 clears lock.
  - While locked, the winner is lock_idx only. Other requesters are never acked, even when lock_idx is idle.
  - o_last is captured with o_dat.
- Without the macro: the ports and lock logic are absent, and every word is arbitrated independently.

Decomposition:
- Package pp_arb_pkg holds:
  - the state enum (ST_EMPTY, ST_FULL);
  - a function computing IW from N;
  - the reset-pointer constant.
- Sub-module pp_rr_pick: combinational rotate-priority picker.
  - Inputs: req[N], ptr[IW].
  - Outputs: gnt_idx[IW], gnt_any.
  - Reused by later schedulers.

Test Plan:
- Reset, then i_rdy=4'b1111 held, i_ack=1 constant: o_src sequence is 0,1,2,3,0,...; o_rdy stays 1 from cycle 1 on with no bubbles.
- i_rdy=4'b0100 only, dat2=8'hA5: o_ack=4'b0100 in cycle 0; cycle 1 shows o_rdy=1, o_dat=A5, o_src=2. Then i_rdy=4'b0011: next grant goes to 0 (ptr=2 wraps), not 1.
- Backpressure: FULL with o_dat=8'h3C and i_ack=0 for 5 cycles while i_rdy=4'b1111: o_ack=0, o_dat/o_src stable all 5 cycles. When i_ack rises, exactly one o_ack fires in that cycle.
- FULL, i_ack=1, i_rdy=0: next cycle o_rdy=0. After 3 idle cycles, i_rdy=4'b1001 with ptr=1: requester 3 granted.
- Assert rst while FULL with i_rdy=4'b1111: o_rdy and o_ack go 0 immediately. After release, requester 0 is granted first.
- PP_ARB_PKT_LOCK_EN: requester 1 sends 3 words (i_last=0,0,1) while requester 0 is always ready: o_src=1,1,1 then 0. A gap in requester 1's rdy mid-packet yields no grants to requester 0.

Source files
------------

// File: rtl/pp_arb_pkg.sv
// Shared types and helpers for the pp_rr_arbiter slice: FSM states, grant-index
// width and the reset value of the last-grant pointer.
package pp_arb_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    // A grant index needs at least one bit, even for the smallest legal N.
    function automatic int calc_iw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // The pointer starts on the last requester so requester 0 wins first.
    function automatic int reset_ptr(input int n);
        return n - 1;
    endfunction

endpackage

// File: rtl/pp_rr_pick.sv
// Combinational rotate-priority picker: returns the first requester at or after
// ptr+1, wrapping modulo N (N need not be a power of two).
module pp_rr_pick
    import pp_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = calc_iw(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    // Scan from the farthest offset down to ptr+1 so the nearest match wins.
    // NOTE: every output gets a default first, so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int off = N; off >= 1; off--) begin
            int cand;
            cand = int'(ptr) + off;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[cand]) begin
                gnt_idx = IW'(cand);
                gnt_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/pp_rr_arbiter.sv
// N-way round-robin arbiter with a one-entry registered output buffer.
// Optional packet locking is enabled by defining PP_ARB_PKT_LOCK_EN.
module pp_rr_arbiter
    import pp_arb_pkg::*;
#(
    parameter  int N  = 4,
    parameter  int BW = 8,
    localparam int IW = calc_iw(N)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    i_rdy,
    input  logic [N*BW-1:0] i_dat,
`ifdef PP_ARB_PKT_LOCK_EN
    input  logic [N-1:0]    i_last,
    output logic            o_last,
`endif
    output logic [N-1:0]    o_ack,
    output logic            o_rdy,
    output logic [BW-1:0]   o_dat,
    output logic [IW-1:0]   o_src,
    input  logic            i_ack
);

    localparam logic [IW-1:0] PTR_RST = IW'(reset_ptr(N));

    state_t        state, next_state;
    logic [IW-1:0] ptr;
    logic [N-1:0]  req;
    logic [IW-1:0] gnt_idx;
    logic          gnt_any;
    logic          can_take;
    logic          accept;

`ifdef PP_ARB_PKT_LOCK_EN
    logic          lock;
    logic [IW-1:0] lock_idx;

    // Mid-packet, only the owner may be granted, even while it is idle.
    always_comb begin
        req = i_rdy;
        if (lock) begin
            req = i_rdy & (N'(1) << lock_idx);
        end
    end
`else
    assign req = i_rdy;
`endif

    pp_rr_pick #(
        .N(N)
    ) u_pick (
        .req     (req),
        .ptr     (ptr),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // can_take is forced low during reset so no producer sees a stray ack.
    always_comb begin
        next_state = state;
        o_ack      = '0;
        can_take   = !rst && ((state == ST_EMPTY) || i_ack);
        if (can_take && gnt_any) begin
            o_ack = N'(1) << gnt_idx;
        end
        accept = |o_ack;
        case (state)
            ST_EMPTY: if (accept) next_state = ST_FULL;
            ST_FULL:  if (i_ack)  next_state = accept ? ST_FULL : ST_EMPTY;
            default:  next_state = ST_EMPTY;
        endcase
    end

    assign o_rdy = (state == ST_FULL);

    // Output buffer and priority pointer only move on an accepted word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_dat    <= '0;
            o_src    <= '0;
            ptr      <= PTR_RST;
`ifdef PP_ARB_PKT_LOCK_EN
            o_last   <= 1'b0;
            lock     <= 1'b0;
            lock_idx <= '0;
`endif
        end else if (accept) begin
            o_dat    <= i_dat[int'(gnt_idx)*BW +: BW];
            o_src    <= gnt_idx;
            ptr      <= gnt_idx;
`ifdef PP_ARB_PKT_LOCK_EN
            o_last   <= i_last[gnt_idx];
            lock     <= !i_last[gnt_idx];
            lock_idx <= gnt_idx;
`endif
        end
    end

endmodule

// File: tb/tb_pp_rr_arbiter.sv
// Scoreboard bench for pp_rr_arbiter; define PP_ARB_PKT_LOCK_EN to also cover
// packet locking.
module tb_pp_rr_arbiter;

    localparam int N  = 4;
    localparam int BW = 8;
    localparam int IW = 2;

    typedef struct packed {
        logic [BW-1:0] dat;
        logic [IW-1:0] src;
        logic          last;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    i_rdy = '0;
    logic [N*BW-1:0] i_dat = '0;
    logic [N-1:0]    o_ack;
    logic            o_rdy;
    logic [BW-1:0]   o_dat;
    logic [IW-1:0]   o_src;
    logic            i_ack = 1'b0;
`ifdef PP_ARB_PKT_LOCK_EN
    logic [N-1:0]    i_last = '0;
    logic            o_last;
`endif

    pp_rr_arbiter #(
        .N  (N),
        .BW (BW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .i_rdy  (i_rdy),
        .i_dat  (i_dat),
`ifdef PP_ARB_PKT_LOCK_EN
        .i_last (i_last),
        .o_last (o_last),
`endif
        .o_ack  (o_ack),
        .o_rdy  (o_rdy),
        .o_dat  (o_dat),
        .o_src  (o_src),
        .i_ack  (i_ack)
    );

    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    exp_t          sb[$];
    logic [BW-1:0] tb_dat[N];
    logic          m_full;
    int            m_ptr;
    logic          m_lock;
    int            m_lock_idx;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_full     = 1'b0;
        m_ptr      = N - 1;
        m_lock     = 1'b0;
        m_lock_idx = 0;
        sb.delete();
    endtask

    // Assert reset mid-cycle, check outputs drop at once, release with inputs idle.
    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_o_rdy", 32'(o_rdy), 32'd0);
        check("rst_o_ack", 32'(o_ack), 32'd0);
        check("rst_o_dat", 32'(o_dat), 32'd0);
        check("rst_o_src", 32'(o_src), 32'd0);
        i_rdy = '0;
        i_ack = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one cycle of stimulus, compare against the model, advance the model.
    task automatic step(input logic [N-1:0] rdy, input logic ack, input logic [N-1:0] last);
        exp_t         e;
        int           win;
        logic         take;
        logic [N-1:0] req;
        logic [N-1:0] exp_ack;
        @(negedge clk);
        i_rdy = rdy;
        i_ack = ack;
`ifdef PP_ARB_PKT_LOCK_EN
        i_last = last;
`endif
        for (int k = 0; k < N; k++) begin
            i_dat[k*BW +: BW] = tb_dat[k];
        end
        #1;
        check("o_rdy", 32'(o_rdy), 32'(m_full));
        if (m_full && sb.size() > 0) begin
            e = sb[0];
            check("o_dat", 32'(o_dat), 32'(e.dat));
            check("o_src", 32'(o_src), 32'(e.src));
`ifdef PP_ARB_PKT_LOCK_EN
            check("o_last", 32'(o_last), 32'(e.last));
`endif
            if (ack) begin
                void'(sb.pop_front());
            end
        end
        take = !m_full || ack;
        req  = rdy;
        if (m_lock) begin
            req = '0;
            req[m_lock_idx] = rdy[m_lock_idx];
        end
        win = -1;
        for (int j = 1; j <= N; j++) begin
            int c;
            c = (m_ptr + j) % N;
            if (win < 0 && req[c]) begin
                win = c;
            end
        end
        exp_ack = '0;
        if (take && win >= 0) begin
            exp_ack[win] = 1'b1;
        end
        check("o_ack", 32'(o_ack), 32'(exp_ack));
        if (exp_ack != '0) begin
            e.dat  = tb_dat[win];
            e.src  = IW'(win);
            e.last = last[win];
            sb.push_back(e);
            m_ptr      = win;
            m_lock     = !last[win];
            m_lock_idx = win;
            tb_dat[win] = BW'($urandom);
            m_full = 1'b1;
        end else if (ack) begin
            m_full = 1'b0;
        end
    endtask

    initial begin
        for (int k = 0; k < N; k++) begin
            tb_dat[k] = BW'(8'h10 + k);
        end
        model_reset();
        repeat (2) @(negedge clk);
        reset_dut();

        // All requesters ready, downstream always accepting: strict rotation, no bubbles.
        for (int i = 0; i < 9; i++) begin
            step(4'b1111, 1'b1, 4'b1111);
            if (i >= 1) begin
                check("rot_o_rdy", 32'(o_rdy), 32'd1);
                check("rot_o_src", 32'(o_src), 32'((i - 1) % N));
            end
        end

        // Single requester, then wrap past ptr=2 to requester 0.
        reset_dut();
        tb_dat[2] = 8'hA5;
        step(4'b0100, 1'b1, 4'b1111);
        check("single_ack", 32'(o_ack), 32'b0100);
        step(4'b0011, 1'b1, 4'b1111);
        check("single_dat", 32'(o_dat), 32'hA5);
        check("single_src", 32'(o_src), 32'd2);
        check("wrap_ack", 32'(o_ack), 32'b0001);

        // Backpressure: hold 3C for five cycles, then exactly one ack on release.
        tb_dat[1] = 8'h3C;
        step(4'b1111, 1'b1, 4'b1111);
        check("bp_fill_ack", 32'(o_ack), 32'b0010);
        for (int i = 0; i < 5; i++) begin
            step(4'b1111, 1'b0, 4'b1111);
            check("bp_ack", 32'(o_ack), 32'd0);
            check("bp_dat", 32'(o_dat), 32'h3C);
            check("bp_src", 32'(o_src), 32'd1);
        end
        step(4'b1111, 1'b1, 4'b1111);
        check("bp_release", 32'($countones(o_ack)), 32'd1);

        // Drain to EMPTY, idle without rotating, then ptr=1 picks requester 3.
        step(4'b0010, 1'b1, 4'b1111);
        step(4'b0000, 1'b1, 4'b1111);
        step(4'b0000, 1'b1, 4'b1111);
        check("drain_o_rdy", 32'(o_rdy), 32'd0);
        step(4'b0000, 1'b1, 4'b1111);
        step(4'b0000, 1'b1, 4'b1111);
        step(4'b1001, 1'b1, 4'b1111);
        check("idle_ack", 32'(o_ack), 32'b1000);

        // Reset while FULL with everyone ready; requester 0 wins afterwards.
        step(4'b1111, 1'b1, 4'b1111);
        step(4'b1111, 1'b0, 4'b1111);
        reset_dut();
        step(4'b1111, 1'b1, 4'b1111);
        check("post_rst_ack", 32'(o_ack), 32'b0001);

`ifdef PP_ARB_PKT_LOCK_EN
        // Requester 1 owns a 3-word packet; requester 0 waits through the gap.
        reset_dut();
        step(4'b0010, 1'b1, 4'b1101);
        check("pkt_w0_ack", 32'(o_ack), 32'b0010);
        step(4'b0011, 1'b1, 4'b1101);
        check("pkt_w1_ack", 32'(o_ack), 32'b0010);
        check("pkt_src0", 32'(o_src), 32'd1);
        step(4'b0001, 1'b1, 4'b1101);
        check("pkt_gap_ack", 32'(o_ack), 32'd0);
        check("pkt_src1", 32'(o_src), 32'd1);
        step(4'b0011, 1'b1, 4'b1111);
        check("pkt_w2_ack", 32'(o_ack), 32'b0010);
        step(4'b0001, 1'b1, 4'b1111);
        check("pkt_src2", 32'(o_src), 32'd1);
        check("pkt_last", 32'(o_last), 32'd1);
        check("pkt_unlock_ack", 32'(o_ack), 32'b0001);
        step(4'b0000, 1'b1, 4'b1111);
        check("pkt_src3", 32'(o_src), 32'd0);
`endif

        step(4'b0000, 1'b1, 4'b1111);
        step(4'b0000, 1'b1, 4'b1111);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
